// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle controller: opcode patterns,
// instruction classes, FSM state encoding and datapath control constants.
package legv8_ctrl_pkg;

    localparam int OPC_BITS = 11;

    // Wildcard opcodes are held as value/mask pairs so no x or z bit is ever compared.
    typedef struct packed {
        logic [OPC_BITS-1:0] val;
        logic [OPC_BITS-1:0] msk;
    } opc_pat_t;

    localparam opc_pat_t PAT_AND  = '{val: 11'b10001010000, msk: 11'b11111111111};
    localparam opc_pat_t PAT_ORR  = '{val: 11'b10101010000, msk: 11'b11111111111};
    localparam opc_pat_t PAT_ADD  = '{val: 11'b10001011000, msk: 11'b11111111111};
    localparam opc_pat_t PAT_SUB  = '{val: 11'b11001011000, msk: 11'b11111111111};
    localparam opc_pat_t PAT_ADDI = '{val: 11'b10010001000, msk: 11'b11111111110};
    localparam opc_pat_t PAT_SUBI = '{val: 11'b11010001000, msk: 11'b11111111110};
    localparam opc_pat_t PAT_MOVZ = '{val: 11'b11010010100, msk: 11'b11111111100};
    localparam opc_pat_t PAT_B    = '{val: 11'b00010100000, msk: 11'b11111100000};
    localparam opc_pat_t PAT_CBZ  = '{val: 11'b10110100000, msk: 11'b11111111000};
    localparam opc_pat_t PAT_CBNZ = '{val: 11'b10110101000, msk: 11'b11111111000};
    localparam opc_pat_t PAT_LDUR = '{val: 11'b11111000010, msk: 11'b11111111111};
    localparam opc_pat_t PAT_STUR = '{val: 11'b11111000000, msk: 11'b11111111111};

    typedef enum logic [3:0] {
        CL_NOP, CL_AND, CL_ORR, CL_ADD, CL_SUB, CL_ADDI, CL_SUBI,
        CL_MOVZ, CL_B, CL_CBZ, CL_CBNZ, CL_LDUR, CL_STUR
    } iclass_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd7
    } state_t;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_MOVZ  = 4'b1000;

    localparam logic [2:0] SGN_I    = 3'b000;
    localparam logic [2:0] SGN_D    = 3'b001;
    localparam logic [2:0] SGN_B    = 3'b010;
    localparam logic [2:0] SGN_CB   = 3'b011;
    localparam logic [2:0] SGN_MOVZ = 3'b100;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;

    typedef struct packed {
        iclass_t    cls;
        logic [3:0] aluop;
        logic [2:0] signop;
    } dec_t;

    localparam dec_t DEC_NOP = '{cls: CL_NOP, aluop: ALU_AND, signop: SGN_I};

    function automatic logic opc_match(input logic [OPC_BITS-1:0] opc, input opc_pat_t pat);
        return (opc & pat.msk) == pat.val;
    endfunction

endpackage

// File: rtl/legv8_opclass_decode.sv
// Combinational opcode classifier: maps IR[31:21] to an instruction class plus
// the ALU operation and immediate-extend select that class needs.
module legv8_opclass_decode
    import legv8_ctrl_pkg::*;
#(
    parameter int OPC_W = OPC_BITS
) (
    input  logic [OPC_W-1:0] opcode,
    output iclass_t          cls,
    output logic             valid,
    output logic [3:0]       aluop,
    output logic [2:0]       signop
);

    logic [OPC_BITS-1:0] op;
    assign op = OPC_BITS'(opcode);

    // NOTE: every output gets a default before the if-chain so no path leaves one unassigned (no latch).
    always_comb begin
        cls    = CL_NOP;
        valid  = 1'b1;
        aluop  = ALU_AND;
        signop = SGN_I;
        if (opc_match(op, PAT_AND)) begin
            cls = CL_AND;
        end else if (opc_match(op, PAT_ORR)) begin
            cls   = CL_ORR;
            aluop = ALU_ORR;
        end else if (opc_match(op, PAT_ADD)) begin
            cls   = CL_ADD;
            aluop = ALU_ADD;
        end else if (opc_match(op, PAT_SUB)) begin
            cls   = CL_SUB;
            aluop = ALU_SUB;
        end else if (opc_match(op, PAT_ADDI)) begin
            cls   = CL_ADDI;
            aluop = ALU_ADD;
        end else if (opc_match(op, PAT_SUBI)) begin
            cls   = CL_SUBI;
            aluop = ALU_SUB;
        end else if (opc_match(op, PAT_MOVZ)) begin
            cls    = CL_MOVZ;
            aluop  = ALU_MOVZ;
            signop = SGN_MOVZ;
        end else if (opc_match(op, PAT_B)) begin
            cls    = CL_B;
            signop = SGN_B;
        end else if (opc_match(op, PAT_CBZ)) begin
            cls    = CL_CBZ;
            aluop  = ALU_PASSB;
            signop = SGN_CB;
        end else if (opc_match(op, PAT_CBNZ)) begin
            cls    = CL_CBNZ;
            aluop  = ALU_PASSB;
            signop = SGN_CB;
        end else if (opc_match(op, PAT_LDUR)) begin
            cls    = CL_LDUR;
            aluop  = ALU_ADD;
            signop = SGN_D;
        end else if (opc_match(op, PAT_STUR)) begin
            cls    = CL_STUR;
            aluop  = ALU_ADD;
            signop = SGN_D;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes.
// Optional perf counters are built when LEGV8_MC_PERF_EN is defined.
module legv8_multicycle_ctrl
    import legv8_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int OPC_W        = 11
) (
    input  logic             Clk,
    input  logic             ResetL,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg2loc,
    output logic             alusrc,
    output logic             mem2reg,
    output logic             regwrite,
    output logic             memread,
    output logic             memwrite,
    output logic [3:0]       aluop,
    output logic [2:0]       signop,
    output logic [2:0]       state,
    output logic             instr_done,
`ifdef LEGV8_MC_PERF_EN
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_instrs,
`endif
    output logic             fault
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt, wait_d;
    dec_t       dec_q;

    iclass_t    dec_cls;
    logic       dec_valid;
    logic [3:0] dec_aluop;
    logic [2:0] dec_signop;
    logic       is_ldur, is_stur, taken;

    legv8_opclass_decode #(.OPC_W(OPC_W)) u_dec (
        .opcode (opcode),
        .cls    (dec_cls),
        .valid  (dec_valid),
        .aluop  (dec_aluop),
        .signop (dec_signop)
    );

    assign is_ldur = (dec_q.cls == CL_LDUR);
    assign is_stur = (dec_q.cls == CL_STUR);
    assign taken   = (dec_q.cls == CL_CBZ) ? zero : !zero;
    assign state   = state_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            state_q  <= ST_FETCH;
            wait_cnt <= '0;
            dec_q    <= DEC_NOP;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_d;
            if (state_q == ST_DECODE) begin
                dec_q <= '{cls: dec_cls, aluop: dec_aluop, signop: dec_signop};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_SEQ;
        reg2loc    = 1'b0;
        alusrc     = 1'b0;
        mem2reg    = 1'b0;
        regwrite   = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        aluop      = ALU_AND;
        signop     = SGN_I;
        instr_done = 1'b0;
        fault      = 1'b0;
        // NOTE: outputs are gated by ResetL itself so strobes drop the moment reset asserts, not at the next edge.
        if (ResetL) begin
            if (state_q inside {ST_EXEC, ST_MEM, ST_WB}) begin
                aluop   = dec_q.aluop;
                signop  = dec_q.signop;
                alusrc  = dec_q.cls inside {CL_ADDI, CL_SUBI, CL_MOVZ, CL_LDUR, CL_STUR};
                reg2loc = dec_q.cls inside {CL_CBZ, CL_CBNZ, CL_STUR};
            end
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_write = 1'b1;
                        state_d  = ST_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        wait_d = wait_cnt + 8'd1;
                    end
                end
                ST_DECODE: state_d = dec_valid ? ST_EXEC : ST_FAULT;
                ST_EXEC: begin
                    case (dec_q.cls)
                        CL_B, CL_CBZ, CL_CBNZ: begin
                            pc_write   = 1'b1;
                            pc_src     = (dec_q.cls == CL_B || taken) ? PCSRC_BR : PCSRC_SEQ;
                            instr_done = 1'b1;
                            state_d    = ST_FETCH;
                        end
                        CL_LDUR, CL_STUR: state_d = ST_MEM;
                        default:          state_d = ST_WB;
                    endcase
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    memread  = is_ldur;
                    memwrite = is_stur;
                    if (dmem_ack) begin
                        if (is_ldur) begin
                            state_d = ST_WB;
                        end else begin
                            pc_write   = 1'b1;
                            instr_done = 1'b1;
                            state_d    = ST_FETCH;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        wait_d = wait_cnt + 8'd1;
                    end
                end
                ST_WB: begin
                    regwrite   = 1'b1;
                    mem2reg    = is_ldur;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end
                ST_FAULT: fault = 1'b1;
                default:  state_d = ST_FAULT;
            endcase
        end
    end

`ifdef LEGV8_MC_PERF_EN
    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            perf_cycles <= '0;
            perf_instrs <= '0;
        end else begin
            if (state_q != ST_FAULT) perf_cycles <= perf_cycles + 32'd1;
            if (instr_done)          perf_instrs <= perf_instrs + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Randomised bench for legv8_multicycle_ctrl: each instruction is expanded into the
// expected per-cycle outputs from the instruction's class and memory wait times.
`timescale 1ns/1ps
module tb_legv8_multicycle_ctrl;

    localparam int MAXW = 15;
    localparam int K_R = 0, K_B = 1, K_CBZ = 2, K_CBNZ = 3, K_LD = 4, K_ST = 5;

    localparam logic [11:0] S_IREQ = 12'h800, S_IRW = 12'h400, S_DREQ = 12'h200;
    localparam logic [11:0] S_MRD  = 12'h100, S_MWR = 12'h080, S_RW   = 12'h040;
    localparam logic [11:0] S_M2R  = 12'h020, S_PCW = 12'h010, S_BR   = 12'h004;
    localparam logic [11:0] S_DONE = 12'h002, S_FLT = 12'h001, S_NONE = 12'h000;

    logic        Clk = 1'b0, ResetL = 1'b0;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic        imem_req, dmem_req, ir_write, pc_write, reg2loc, alusrc;
    logic        mem2reg, regwrite, memread, memwrite, instr_done, fault;
    logic [1:0]  pc_src;
    logic [3:0]  aluop;
    logic [2:0]  signop, state;
`ifdef LEGV8_MC_PERF_EN
    logic [31:0] perf_cycles, perf_instrs;
`endif

    legv8_multicycle_ctrl #(.MEM_WAIT_MAX(MAXW), .OPC_W(11)) dut (
        .Clk(Clk), .ResetL(ResetL), .opcode(opcode), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg2loc(reg2loc),
        .alusrc(alusrc), .mem2reg(mem2reg), .regwrite(regwrite), .memread(memread),
        .memwrite(memwrite), .aluop(aluop), .signop(signop), .state(state),
        .instr_done(instr_done),
`ifdef LEGV8_MC_PERF_EN
        .perf_cycles(perf_cycles), .perf_instrs(perf_instrs),
`endif
        .fault(fault)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [10:0] base;
        int          dc;
        int          kind;
        logic [3:0]  aluop;
        logic        alusrc;
        logic        reg2loc;
        logic [2:0]  signop;
    } itab_t;

    typedef struct {
        logic [2:0]  st;
        logic [11:0] strb;
        int          alu_mode;  // 0: expect idle zeros, 1: expect class values, 2: not compared
        itab_t       t;
        logic        ia, da, z;
        logic [10:0] opc;
    } cyc_t;

    cyc_t q[$];
    int   total = 0, bad = 0, cyc_n = 0, exp_cyc = 0, exp_ins = 0;
    bit   faulted = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc_n, got, exp);
        end
    endtask

    function automatic itab_t lookup(input int k);
        itab_t t;
        t = '{11'b0, 0, K_R, 4'b0000, 1'b0, 1'b0, 3'b000};
        case (k)
            1:  t = '{11'b10001010000, 0, K_R,    4'b0000, 1'b0, 1'b0, 3'b000};
            2:  t = '{11'b10101010000, 0, K_R,    4'b0001, 1'b0, 1'b0, 3'b000};
            3:  t = '{11'b10001011000, 0, K_R,    4'b0010, 1'b0, 1'b0, 3'b000};
            4:  t = '{11'b11001011000, 0, K_R,    4'b0110, 1'b0, 1'b0, 3'b000};
            5:  t = '{11'b10010001000, 1, K_R,    4'b0010, 1'b1, 1'b0, 3'b000};
            6:  t = '{11'b11010001000, 1, K_R,    4'b0110, 1'b1, 1'b0, 3'b000};
            7:  t = '{11'b11010010100, 2, K_R,    4'b1000, 1'b1, 1'b0, 3'b100};
            8:  t = '{11'b00010100000, 5, K_B,    4'b0000, 1'b0, 1'b0, 3'b010};
            9:  t = '{11'b10110100000, 3, K_CBZ,  4'b0111, 1'b0, 1'b1, 3'b011};
            10: t = '{11'b10110101000, 3, K_CBNZ, 4'b0111, 1'b0, 1'b1, 3'b011};
            11: t = '{11'b11111000010, 0, K_LD,   4'b0010, 1'b1, 1'b0, 3'b001};
            12: t = '{11'b11111000000, 0, K_ST,   4'b0010, 1'b1, 1'b1, 3'b001};
            default: ;
        endcase
        return t;
    endfunction

    function automatic int classify(input logic [10:0] op);
        casez (op)
            11'b10001010000: return 1;
            11'b10101010000: return 2;
            11'b10001011000: return 3;
            11'b11001011000: return 4;
            11'b1001000100?: return 5;
            11'b1101000100?: return 6;
            11'b110100101??: return 7;
            11'b000101?????: return 8;
            11'b10110100???: return 9;
            11'b10110101???: return 10;
            11'b11111000010: return 11;
            11'b11111000000: return 12;
            default:         return 0;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [10:0] ro();
        return 11'($urandom);
    endfunction

    function automatic logic [11:0] dut_strb();
        return {imem_req, ir_write, dmem_req, memread, memwrite, regwrite,
                mem2reg, pc_write, pc_src, instr_done, fault};
    endfunction

    task automatic push(input logic [2:0] st, input logic [11:0] strb, input int mode,
                        input itab_t t, input logic ia, input logic da, input logic z,
                        input logic [10:0] opc);
        cyc_t c;
        c.st = st; c.strb = strb; c.alu_mode = mode; c.t = t;
        c.ia = ia; c.da = da; c.z = z; c.opc = opc;
        q.push_back(c);
    endtask

    task automatic push_fault();
        faulted = 1'b1;
        for (int i = 0; i < 4; i++) push(3'd7, S_FLT, 0, lookup(0), rb(), rb(), rb(), ro());
    endtask

    // Expected cycle-by-cycle behaviour of one instruction given its memory wait times.
    task automatic plan(input logic [10:0] op, input int idly, input int ddly, input logic z);
        int    k;
        itab_t t, nul;
        logic  ld, brt;
        k   = classify(op);
        t   = lookup(k);
        nul = lookup(0);
        ld  = (t.kind == K_LD);
        for (int i = 0; i < idly && i < MAXW; i++)
            push(3'd0, S_IREQ, 0, nul, 1'b0, rb(), rb(), ro());
        if (idly >= MAXW) begin push_fault(); return; end
        push(3'd0, S_IREQ | S_IRW, 0, nul, 1'b1, rb(), rb(), ro());
        push(3'd1, S_NONE, 0, nul, rb(), rb(), rb(), op);
        if (k == 0) begin push_fault(); return; end
        case (t.kind)
            K_B:  push(3'd2, S_PCW | S_BR | S_DONE, 1, t, rb(), rb(), rb(), ro());
            K_CBZ, K_CBNZ: begin
                brt = (t.kind == K_CBZ) ? z : !z;
                push(3'd2, S_PCW | (brt ? S_BR : S_NONE) | S_DONE, 1, t, rb(), rb(), z, ro());
            end
            K_R: begin
                push(3'd2, S_NONE, 1, t, rb(), rb(), rb(), ro());
                push(3'd4, S_RW | S_PCW | S_DONE, 2, t, rb(), rb(), rb(), ro());
            end
            default: begin
                push(3'd2, S_NONE, 1, t, rb(), rb(), rb(), ro());
                for (int i = 0; i < ddly && i < MAXW; i++)
                    push(3'd3, S_DREQ | (ld ? S_MRD : S_MWR), 1, t, rb(), 1'b0, rb(), ro());
                if (ddly >= MAXW) begin push_fault(); return; end
                push(3'd3, S_DREQ | (ld ? S_MRD : (S_MWR | S_PCW | S_DONE)), 1, t,
                     rb(), 1'b1, rb(), ro());
                if (ld) push(3'd4, S_RW | S_M2R | S_PCW | S_DONE, 2, t, rb(), rb(), rb(), ro());
            end
        endcase
    endtask

    // Entered and left just after a falling edge; inputs change there, outputs are sampled 1ns later.
    task automatic run_cycle(input cyc_t c);
        imem_ack = c.ia; dmem_ack = c.da; zero = c.z; opcode = c.opc;
        #1;
        check("state", 32'(state), 32'(c.st));
        check("strobes", 32'(dut_strb()), 32'(c.strb));
        if (c.alu_mode == 1)
            check("alu_ctrl", 32'({aluop, alusrc, reg2loc, signop}),
                  32'({c.t.aluop, c.t.alusrc, c.t.reg2loc, c.t.signop}));
        else if (c.alu_mode == 0)
            check("alu_idle", 32'({aluop, alusrc, reg2loc, signop}), 32'(0));
        if (c.st != 3'd7) exp_cyc++;
        if ((c.strb & S_DONE) != 0) exp_ins++;
        cyc_n++;
        @(negedge Clk);
    endtask

    task automatic run_all();
        while (q.size() > 0) run_cycle(q.pop_front());
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n && q.size() > 0; i++) run_cycle(q.pop_front());
    endtask

    task automatic perf_check();
`ifdef LEGV8_MC_PERF_EN
        check("perf_cycles", perf_cycles, 32'(exp_cyc));
        check("perf_instrs", perf_instrs, 32'(exp_ins));
`endif
    endtask

    task automatic do_reset();
        ResetL = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; zero = 1'b1; opcode = ro();
        #1;
        check("rst_state", 32'(state), 32'(0));
        check("rst_strobes", 32'(dut_strb()), 32'(0));
        check("rst_alu", 32'({aluop, alusrc, reg2loc, signop}), 32'(0));
`ifdef LEGV8_MC_PERF_EN
        check("rst_perf", perf_cycles | perf_instrs, 32'(0));
`endif
        @(negedge Clk);
        @(negedge Clk);
        ResetL  = 1'b1;
        exp_cyc = 0;
        exp_ins = 0;
        faulted = 1'b0;
    endtask

    task automatic end_fault();
        perf_check();
        do_reset();
    endtask

    initial begin
        int          k, idly, ddly, r;
        itab_t       t;
        logic [10:0] op;

        do_reset();
        plan(11'b10001011000, 0, 0, 1'b0); run_all();        // ADD, zero-wait
        plan(11'b11111000010, 0, 3, 1'b0); run_all();        // LDUR, dmem_ack after 3 waits
        plan(11'b10110100101, 0, 0, 1'b1);                   // CBZ taken
        plan(11'b10110101011, 0, 0, 1'b1); run_all();        // CBNZ not taken
        plan(11'b00010110011, 1, 0, 1'b0);                   // B
        plan(11'b11111000000, 2, 2, 1'b0);                   // STUR
        plan(11'b11010010111, 0, 0, 1'b0);                   // MOVZ
        plan(11'b10010001001, 0, 0, 1'b0); run_all();        // ADDI
        perf_check();

        plan(11'b00000000000, 0, 0, 1'b0); run_all(); end_fault();
        plan(11'b10001011000, MAXW, 0, 1'b0); run_all(); end_fault();
        plan(11'b10001011000, MAXW - 1, 0, 1'b0); run_all();
        plan(11'b11111000000, 0, MAXW, 1'b0); run_all(); end_fault();
        plan(11'b11111000010, 0, MAXW - 1, 1'b0); run_all();

        // Reset pulled mid-way through a STUR's memory wait.
        plan(11'b11111000000, 0, 6, 1'b0);
        run_n(5);
        imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        check("abort_pre_memwrite", 32'(memwrite), 32'(1));
        #1 ResetL = 1'b0;
        #1;
        check("abort_memwrite", 32'(memwrite), 32'(0));
        check("abort_strobes", 32'(dut_strb()), 32'(0));
        check("abort_state", 32'(state), 32'(0));
        q.delete();
        @(negedge Clk);
        ResetL = 1'b1; exp_cyc = 0; exp_ins = 0;
        plan(11'b10001011000, 0, 0, 1'b0); run_all();

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = ro();
            end else begin
                k  = $urandom_range(1, 12);
                t  = lookup(k);
                op = t.base | (ro() & ((11'd1 << t.dc) - 11'd1));
            end
            r    = $urandom_range(0, 19);
            idly = (r == 0) ? MAXW : (r == 1) ? MAXW - 1 : $urandom_range(0, 3);
            r    = $urandom_range(0, 19);
            ddly = (r == 0) ? MAXW : (r == 1) ? MAXW - 1 : $urandom_range(0, 3);
            plan(op, idly, ddly, rb());
            run_all();
            if (faulted) end_fault();
        end
        perf_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/legv8_multicycle_ctrl.md
Name: legv8_multicycle_ctrl

Overview:
Multi-cycle sequencer for the LEGv8 datapath. It replaces single-cycle decode with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It issues request/ack handshakes to instruction and data memory, and drives the same control strobes the datapath already consumes. It sits between the instruction register and the datapath muxes, register file and memories.

Parameters:
MEM_WAIT_MAX, 15, maximum cycles spent waiting for imem_ack or dmem_ack before entering FAULT (1..255).
OPC_W, 11, opcode width.

Ports:
Clk  in  1  system clock, rising edge
ResetL  in  1  asynchronous, active-low reset
opcode  in  OPC_W  IR[31:21]
zero  in  1  ALU zero flag, valid in EXEC
imem_ack  in  1  instruction word valid; IR may load this cycle
dmem_ack  in  1  data access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
ir_write  out  1  load IR
pc_write  out  1  update PC
pc_src  out  2  00 = PC+4, 01 = branch target, others reserved
reg2loc, alusrc, mem2reg, regwrite, memread, memwrite  out  1 each  datapath strobes, same meaning as the existing decoder
aluop  out  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B, 1000 MOVZ
signop  out  3  immediate-extend select
state  out  3  current FSM state (debug)
instr_done  out  1  one-cycle pulse on instruction retire
fault  out  1  sticky: illegal opcode or memory timeout

Behaviour:
- Clock and reset: one clock, Clk. Reset ResetL is asynchronous, active-low.
- While ResetL=0: state=FETCH, wait counter=0, latched class=NOP, fault=0. All outputs are 0, with aluop=0000 and signop=000. The first cycle after release is FETCH with imem_req=1.
- All x-valued don't-cares are forbidden. Unused strobes drive 0.
- FETCH:
  - imem_req=1.
  - If imem_ack: ir_write=1, go to DECODE.
  - Else increment wait counter. When the counter reaches MEM_WAIT_MAX, go to FAULT.
- DECODE:
  - One cycle. Classify opcode with the existing casex patterns (AND/ORR/ADD/SUB reg, ADDI/SUBI, MOVZ, B, CBZ, CBNZ, LDUR, STUR) and register the class.
  - No match: go to FAULT.
- EXEC:
  - Drive alusrc/reg2loc/aluop/signop for the class.
  - R-type, I-type, MOVZ: go to WB.
  - LDUR/STUR: go to MEM.
  - B: pc_write=1, pc_src=01, instr_done=1, go to FETCH.
  - CBZ/CBNZ: taken = zero (CBZ) or !zero (CBNZ). pc_write=1, pc_src = taken ? 01 : 00, instr_done=1, go to FETCH.
- MEM:
  - dmem_req=1, memread (LDUR) or memwrite (STUR) held steady until dmem_ack. Address strobes stay stable.
  - On ack: LDUR goes to WB. STUR asserts pc_write=1, pc_src=00, instr_done=1 and goes to FETCH.
  - Timeout handled as in FETCH.
- WB:
  - regwrite=1, mem2reg=1 for LDUR else 0, pc_write=1, pc_src=00, instr_done=1, go to FETCH.
- FAULT: terminal until reset. fault=1, all strobes 0, no requests.
- Wait counter clears on every state change. An ack arriving in the same cycle the counter reaches MEM_WAIT_MAX wins: the handshake completes and no fault is raised.
- Outputs are Moore on state and class, except three Mealy exceptions: ir_write (imem_ack), pc_src in EXEC (zero), and the retire strobes in MEM (dmem_ack).
- Latency with zero-wait memory: branch 3 cycles; R/I/MOVZ and STUR 4 cycles; LDUR 5 cycles.
- Reset asserted mid-instruction aborts immediately. No partial writes occur after ResetL falls.

Optional Feature:
Macro LEGV8_MC_PERF_EN.
- Defined: adds outputs perf_cycles[31:0] and perf_instrs[31:0].
  - perf_cycles increments every non-FAULT cycle.
  - perf_instrs increments on instr_done.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package legv8_ctrl_pkg: opcode casex patterns, instruction-class enum, FSM state encoding (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7), aluop and pc_src constants.
- Sub-module legv8_opclass_decode: combinational opcode -> {class, valid, aluop, signop}, instantiated once.

Test Plan:
- ADDREG (opcode 10001011000), immediate acks -> state sequence 0,1,2,4,0; regwrite=1 only in the WB cycle; aluop=0010; instr_done after 4 cycles.
- LDUR with dmem_ack delayed 3 cycles -> memread and dmem_req high for 4 cycles; then WB with mem2reg=1; 8 cycles total.
- CBZ with zero=1, then CBNZ with zero=1 -> first gives pc_src=01, second gives pc_src=00; both pc_write=1 in EXEC; no regwrite.
- Illegal opcode 00000000000 -> FAULT after DECODE; fault=1 sticky; all strobes 0 until ResetL low.
- imem_ack never asserted, MEM_WAIT_MAX=15 -> FAULT entered after 15 FETCH cycles; ack on cycle 15 instead -> no fault.
- ResetL pulled low during MEM of STUR -> memwrite drops asynchronously; after release, FETCH with imem_req=1.
